bcd_serial_subtractor: RTL and testbench
========================================

Name: bcd_serial_subtractor

Overview:
Multi-digit packed-BCD subtractor computing |a - b| plus a sign flag. It processes one BCD digit per clock, least-significant digit first, through a shared digit-subtract cell with a registered borrow. A negative raw result gets a second serial 10's-complement pass. It is the subtract counterpart to the combinational BCD add path and uses a start/busy/done handshake so it can sit behind a register-mapped arithmetic unit.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0]; latched on accepted start
b  input  4*DIGITS  subtrahend, packed BCD; latched on accepted start
busy  output  1  high from the cycle after an accepted start until done deasserts
done  output  1  single-cycle pulse when the result is valid
diff  output  4*DIGITS  |a-b| in packed BCD; holds until the next done
neg  output  1  1 when a < b; updates with diff
err  output  1  invalid-digit flag (see Optional Feature); updates with diff

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, diff=0, neg=0, err=0, internal digit index, borrow and work registers cleared. Reset asserted mid-operation aborts the operation; no done is produced.
- FSM states: IDLE, SUB, FIX, DONE.
  - IDLE -> SUB on start=1. Latch a and b; work register=0; idx=0; borrow=0.
  - SUB, one digit per cycle: {bout,d} = digit_sub(a[idx], b[idx], borrow); write d to work[idx]; borrow<=bout; idx++.
  - After digit DIGITS-1: go to FIX if final bout=1, else go to DONE. Reset idx and borrow to 0 when entering FIX.
  - FIX, one digit per cycle: work[idx] = digit_sub(0, work[idx], borrow), which gives the 10's complement. After digit DIGITS-1, go to DONE.
  - DONE, one cycle: done=1; diff<=work; neg<=(FIX was taken); err per feature; next state IDLE.
- busy=1 in SUB, FIX and DONE; busy=0 in IDLE.
- Latency, with start accepted at edge T: a non-negative result has done high in cycle T+DIGITS+1; a negative result has done high in cycle T+2*DIGITS+1.
- start is ignored in SUB, FIX and DONE, and is not queued. A start in the cycle after done (IDLE) is accepted.
- Digit arithmetic: t = x - y - bin in 5-bit signed; if t<0 then d=t+10 and bout=1, else d=t and bout=0. d is always 0..9 for valid inputs.
- a == b gives diff=0 and neg=0. A negative zero is never produced.
- diff, neg and err change only at the DONE transition and are stable otherwise.

Optional Feature:
Macro BCD_SUB_DIGIT_CHECK_EN.
- Defined: on accepted start, any latched nibble of a or b greater than 9 sets an internal flag. The operation still runs its normal cycle count. In DONE, err=1, diff=0 and neg=0.
- Not defined: no checking; err is tied to 0. Invalid nibbles go through the same digit arithmetic and produce a result with no guarantee of BCD validity.

Decomposition:
- Package bcd_pkg holds: DIGIT_W=4; BCD_MAX=4'd9; BCD_RADIX=5'd10; the state enum {IDLE,SUB,FIX,DONE}.
- Sub-module bcd_digit_sub is purely combinational: inputs x[3:0], y[3:0], bin; outputs d[3:0], bout. A single instance is shared by SUB and FIX through an input mux.

Test Plan:
- DIGITS=4, a=16'h5432, b=16'h1234, start at T -> done=1 only in cycle T+5; diff=16'h4198, neg=0, err=0; busy high for cycles T+1..T+5.
- a=16'h1234, b=16'h5432 -> done in cycle T+9; diff=16'h4198, neg=1.
- a=16'h0000, b=16'h0001 -> diff=16'h0001, neg=1. a=16'h9999, b=16'h9999 -> diff=16'h0000, neg=0. a=16'h1000, b=16'h0001 -> diff=16'h0999 (full borrow ripple).
- start re-pulsed at T+2 with different operands -> ignored; the first result is delivered unchanged; a start in the cycle after done is accepted and completes normally.
- rst asserted at T+3 of a negative operation -> busy, done, diff and neg are 0 immediately; no done pulse follows; the next operation is correct.
- With BCD_SUB_DIGIT_CHECK_EN: a=16'h00A0, b=16'h0001 -> done at T+5 with err=1, diff=0, neg=0. Without the macro, err stays 0 across the full 0..9 x 0..9 single-digit sweep, which is checked against a reference model.

Source files
------------

// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared types and constants for the serial packed-BCD subtractor.
// Holds the digit geometry, the FSM state encoding and a digit validity helper.
package bcd_pkg;

    localparam int          DIGIT_W   = 4;
    localparam logic [3:0]  BCD_MAX   = 4'd9;
    localparam logic [4:0]  BCD_RADIX = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] nib);
        return nib > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_subtractor_digit_sub.sv
// Single BCD digit subtract cell: {bout, d} = x - y - bin, wrapped into 0..9.
// Purely combinational; one instance is time-shared between the SUB and FIX passes.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    logic [4:0] t;
    logic [4:0] t_wrap;

    // 5 bits cover -16..15, enough for any nibble pair plus borrow
    always_comb begin
        t      = {1'b0, x} - {1'b0, y} - {4'd0, bin};
        t_wrap = t + BCD_RADIX;
        bout   = t[4];
        d      = t[4] ? t_wrap[DIGIT_W-1:0] : t[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Serial packed-BCD |a - b| with sign, one digit per clock, LSD first.
// Optional invalid-digit flag enabled by defining BCD_SUB_DIGIT_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start; operands latched when start is seen
// SUB   | raw digit-serial a - b into work, borrow carried between digits
// FIX   | raw result was negative; 10's complement of work, digit-serial
// DONE  | one-cycle result cycle, done high; back to IDLE next
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] diff,
    output logic                      neg,
    output logic                      err
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t             state;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       work;
    logic [W-1:0]       work_nxt;
    logic [IDX_W-1:0]   idx;
    logic               borrow;

    logic [DIGIT_W-1:0] cell_x;
    logic [DIGIT_W-1:0] cell_y;
    logic [DIGIT_W-1:0] cell_d;
    logic               cell_bout;
    logic               last_digit;
    logic               load_result;
    logic               bad;

    // FIX reuses the cell as 0 - work[idx] - borrow
    always_comb begin
        cell_x = '0;
        cell_y = b_q[idx*DIGIT_W +: DIGIT_W];
        if (state == FIX) begin
            cell_y = work[idx*DIGIT_W +: DIGIT_W];
        end else begin
            cell_x = a_q[idx*DIGIT_W +: DIGIT_W];
        end
    end

    bcd_digit_sub u_digit_sub (
        .x    (cell_x),
        .y    (cell_y),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        work_nxt = work;
        work_nxt[idx*DIGIT_W +: DIGIT_W] = cell_d;
    end

    // Result is loaded on the edge that enters DONE, so it appears together with done
    assign last_digit  = (idx == LAST_IDX);
    assign load_result = last_digit && ((state == FIX) || (state == SUB && !cell_bout));

`ifdef BCD_SUB_DIGIT_CHECK_EN
    logic bad_q;
    logic in_bad;

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(a[i*DIGIT_W +: DIGIT_W]) || digit_invalid(b[i*DIGIT_W +: DIGIT_W])) begin
                in_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                bad_q <= in_bad;
            end
            if (load_result) begin
                err <= bad_q;
            end
        end
    end

    assign bad = bad_q;
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            neg    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            work   <= '0;
            idx    <= '0;
            borrow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        work   <= '0;
                        idx    <= '0;
                        borrow <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    work   <= work_nxt;
                    borrow <= cell_bout;
                    idx    <= idx + 1'b1;
                    if (last_digit) begin
                        if (cell_bout) begin
                            idx    <= '0;
                            borrow <= 1'b0;
                            state  <= FIX;
                        end else begin
                            done  <= 1'b1;
                            diff  <= bad ? '0 : work_nxt;
                            neg   <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                FIX: begin
                    work   <= work_nxt;
                    borrow <= cell_bout;
                    idx    <= idx + 1'b1;
                    if (last_digit) begin
                        done  <= 1'b1;
                        diff  <= bad ? '0 : work_nxt;
                        neg   <= !bad;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=4), sampling on the falling edge.
// The invalid-digit case follows BCD_SUB_DIGIT_CHECK_EN when it is defined.
module tb_bcd_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        neg;
    logic        err;

    int n_vec;
    int n_err;

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .neg   (neg),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge of cycle T+1
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int k, output int busy_low);
        k = k0;
        busy_low = 0;
        while (k < 40) begin
            if (!busy) busy_low++;
            if (done) break;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic finish_op(input string tag, input int k, input int bl, input logic [15:0] ed,
                             input logic en, input logic ee, input int elat);
        chk({tag, "/lat"}, 32'(k), 32'(elat));
        chk({tag, "/diff"}, 32'(diff), 32'(ed));
        chk({tag, "/neg"}, 32'(neg), 32'(en));
        chk({tag, "/err"}, 32'(err), 32'(ee));
        chk({tag, "/busy"}, 32'(bl), 32'd0);
        @(negedge clk);
        chk({tag, "/done_pulse"}, 32'(done), 32'd0);
        chk({tag, "/busy_off"}, 32'(busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] ed, input logic en, input logic ee, input int elat);
        int k;
        int bl;
        start_op(av, bv);
        wait_done(1, k, bl);
        finish_op(tag, k, bl, ed, en, ee, elat);
    endtask

    initial begin
        int k;
        int bl;
        int cnt;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/diff", 32'(diff), 32'd0);
        chk("rst/neg", 32'(neg), 32'd0);
        chk("rst/err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("pos",    16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 5);
        run_op("negv",   16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 9);
        run_op("zm1",    16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 9);
        run_op("ripple", 16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5);
        run_op("mid",    16'h0499, 16'h0500, 16'h0001, 1'b1, 1'b0, 9);
        run_op("top",    16'h9000, 16'h0001, 16'h8999, 1'b0, 1'b0, 5);
        run_op("eq",     16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5);

        // restart while busy is ignored; diff holds the previous result meanwhile
        start_op(16'h5432, 16'h1234);
        @(negedge clk);
        a = 16'h9999;
        b = 16'h0000;
        start = 1'b1;
        chk("ign/hold", 32'(diff), 32'h0000);
        @(negedge clk);
        start = 1'b0;
        wait_done(3, k, bl);
        finish_op("ign", k, bl, 16'h4198, 1'b0, 1'b0, 5);
        run_op("b2b", 16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 9);

        // abort a negative operation with reset at T+3
        start_op(16'h1234, 16'h5432);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/done", 32'(done), 32'd0);
        chk("abort/diff", 32'(diff), 32'd0);
        chk("abort/neg", 32'(neg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("abort/quiet", 32'(cnt), 32'd0);
        run_op("after", 16'h0500, 16'h0499, 16'h0001, 1'b0, 1'b0, 5);

`ifdef BCD_SUB_DIGIT_CHECK_EN
        run_op("inval", 16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 5);
        run_op("clear", 16'h0020, 16'h0001, 16'h0019, 1'b0, 1'b0, 5);
`else
        // unchecked: A-0-1 = 9 in digit 1, 0-1 wraps to 9 in digit 0
        run_op("inval", 16'h00A0, 16'h0001, 16'h0099, 1'b0, 1'b0, 5);
`endif

        for (int x = 0; x < 10; x++) begin
            for (int y = 0; y < 10; y++) begin
                int v;
                v = x - y;
                run_op($sformatf("sw%0d_%0d", x, y), 16'(x), 16'(y),
                       to_bcd(v < 0 ? -v : v), v < 0, 1'b0, v < 0 ? 9 : 5);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
